// File: rtl/demux_sched_4b.sv
`default_nettype none
// ============================================================================
// Module      : demux_sched_4b
// Description : Round-robin scheduler that spreads a stream of words from one
//               input bus across two registered output lanes, with
//               valid/ready backpressure on both sides, per-lane delivered-word
//               counters and an enable/drain run control.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sched_4b #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    input  logic             ready_in0,
    input  logic             ready_in1,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_sel;
    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic             r_valid0;
    logic             r_valid1;
    logic [CNT_W-1:0] r_count0;
    logic [CNT_W-1:0] r_count1;

    logic w_avail0;
    logic w_avail1;
    logic w_pref_avail;
    logic w_lane;
    logic w_ready;
    logic w_accept;
    logic w_xfer0;
    logic w_xfer1;
    logic w_load0;
    logic w_load1;

    // A lane can take a word if its buffer is empty or is being emptied now;
    // the preferred lane wins when it can take the word, otherwise the other.
    assign w_avail0     = !r_valid0 || ready_in0;
    assign w_avail1     = !r_valid1 || ready_in1;
    assign w_ready      = (r_state == ST_RUN) && (w_avail0 || w_avail1);
    assign w_accept     = valid_in && w_ready;
    assign w_pref_avail = r_sel ? w_avail1 : w_avail0;
    assign w_lane       = w_pref_avail ? r_sel : ~r_sel;
    assign w_load0      = w_accept && !w_lane;
    assign w_load1      = w_accept && w_lane;
    assign w_xfer0      = r_valid0 && ready_in0;
    assign w_xfer1      = r_valid1 && ready_in1;

    assign ready_out  = w_ready;
    assign data_out0  = r_data0;
    assign data_out1  = r_data1;
    assign valid_out0 = r_valid0;
    assign valid_out1 = r_valid1;
    assign sel        = r_sel;
    assign busy       = r_busy;
    assign count0     = r_count0;
    assign count1     = r_count1;

    // Run-control FSM; busy is registered alongside the state it reflects.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                    end else if (!r_valid0 && !r_valid1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer: points past the lane that took the last word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sel <= 1'b0;
        end else if (w_accept) begin
            r_sel <= ~w_lane;
        end
    end

    // Lane buffers: a reload in the same cycle as a transfer keeps valid high.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data0  <= '0;
            r_data1  <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            if (w_load0) begin
                r_data0  <= data_in;
                r_valid0 <= 1'b1;
            end else if (w_xfer0) begin
                r_valid0 <= 1'b0;
            end
            if (w_load1) begin
                r_data1  <= data_in;
                r_valid1 <= 1'b1;
            end else if (w_xfer1) begin
                r_valid1 <= 1'b0;
            end
        end
    end

    // Delivered-word counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            if (w_xfer0) begin
                r_count0 <= r_count0 + c_cnt_one;
            end
            if (w_xfer1) begin
                r_count1 <= r_count1 + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_sched_4b.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_sched_4b
// Description : Self-checking bench for demux_sched_4b: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a behavioural lane/queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_sched_4b;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic             valid_out0;
    logic             valid_out1;
    logic             ready_in0 = 1'b0;
    logic             ready_in1 = 1'b0;
    logic             sel;
    logic             busy;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;

    int n_tot = 0;
    int n_bad = 0;

    demux_sched_4b #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (enable),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .ready_in0  (ready_in0),
        .ready_in1  (ready_in1),
        .sel        (sel),
        .busy       (busy),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: mode 0=idle 1=run 2=drain, two lane slots,
    // integer delivery counts reduced modulo 2^CNT_W.
    // ------------------------------------------------------------------
    int         m_mode;
    int         m_sel;
    logic       m_v[2];
    logic [3:0] m_d[2];
    int         m_cnt[2];

    int         nx_mode;
    int         nx_sel;
    logic       nx_v[2];
    logic [3:0] nx_d[2];
    int         nx_cnt[2];
    logic       m_av[2];
    logic       m_rdy;
    int         m_ln;

    always_comb begin
        nx_mode = m_mode;
        nx_sel  = m_sel;
        m_ln    = 0;
        m_av[0] = !m_v[0] || ready_in0;
        m_av[1] = !m_v[1] || ready_in1;
        m_rdy   = (m_mode == 1) && (m_av[0] || m_av[1]);
        nx_v[0] = m_v[0];  nx_v[1] = m_v[1];
        nx_d[0] = m_d[0];  nx_d[1] = m_d[1];
        nx_cnt[0] = m_cnt[0];
        nx_cnt[1] = m_cnt[1];
        if (m_v[0] && ready_in0) begin
            nx_cnt[0] = (m_cnt[0] + 1) % (1 << CNT_W);
            nx_v[0]   = 1'b0;
        end
        if (m_v[1] && ready_in1) begin
            nx_cnt[1] = (m_cnt[1] + 1) % (1 << CNT_W);
            nx_v[1]   = 1'b0;
        end
        if (valid_in && m_rdy) begin
            m_ln       = m_av[m_sel] ? m_sel : 1 - m_sel;
            nx_d[m_ln] = data_in;
            nx_v[m_ln] = 1'b1;
            nx_sel     = 1 - m_ln;
        end
        if (m_mode == 0 && enable)
            nx_mode = 1;
        else if (m_mode == 1 && !enable)
            nx_mode = 2;
        else if (m_mode == 2)
            nx_mode = enable ? 1 : ((!m_v[0] && !m_v[1]) ? 0 : 2);
    end

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_mode <= 0;
            m_sel  <= 0;
            for (int i = 0; i < 2; i++) begin
                m_v[i]   <= 1'b0;
                m_d[i]   <= '0;
                m_cnt[i] <= 0;
            end
        end else begin
            m_mode <= nx_mode;
            m_sel  <= nx_sel;
            for (int i = 0; i < 2; i++) begin
                m_v[i]   <= nx_v[i];
                m_d[i]   <= nx_d[i];
                m_cnt[i] <= nx_cnt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("ready_out", int'(ready_out), int'(m_rdy));
        chk("sel", int'(sel), m_sel);
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("valid_out0", int'(valid_out0), int'(m_v[0]));
        chk("valid_out1", int'(valid_out1), int'(m_v[1]));
        chk("data_out0", int'(data_out0), int'(m_d[0]));
        chk("data_out1", int'(data_out1), int'(m_d[1]));
        chk("count0", int'(count0), m_cnt[0]);
        chk("count1", int'(count1), m_cnt[1]);
    endtask

    task automatic set_in(input logic en, input logic vin, input logic [3:0] d,
                          input logic r0, input logic r1);
        enable    = en;
        valid_in  = vin;
        data_in   = d;
        ready_in0 = r0;
        ready_in1 = r1;
    endtask

    // One cycle: check at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset between edges, released away from the clock edge.
    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk("rst_valid0", int'(valid_out0), 0);
        chk("rst_valid1", int'(valid_out1), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count0", int'(count0), 0);
        compare_all();
        @(posedge clk);
        #2;
        reset_L = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 4'h0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_L = 1'b1;
        chk("init_busy", int'(busy), 0);
        chk("init_ready", int'(ready_out), 0);
        chk("init_count1", int'(count1), 0);

        // Reset with both lanes holding words, then stay idle after release.
        set_in(1, 0, 4'h0, 0, 0); tick();
        set_in(1, 1, 4'hC, 0, 0); tick();
        set_in(1, 1, 4'hD, 0, 0); tick();
        chk("pre_rst_v0", int'(valid_out0), 1);
        chk("pre_rst_v1", int'(valid_out1), 1);
        set_in(0, 0, 4'h0, 0, 0);
        do_reset();
        tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ready", int'(ready_out), 0);

        // Alternation with both consumers ready.
        set_in(1, 0, 4'h0, 1, 1); tick();
        set_in(1, 1, 4'hF, 1, 1); tick();
        chk("alt_d0_first", int'(data_out0), 'hF);
        chk("alt_v0_first", int'(valid_out0), 1);
        set_in(1, 1, 4'h3, 1, 1); tick();
        chk("alt_d1_first", int'(data_out1), 'h3);
        set_in(1, 1, 4'h7, 1, 1); tick();
        chk("alt_d0_second", int'(data_out0), 'h7);
        set_in(1, 1, 4'hA, 1, 1); tick();
        chk("alt_d1_second", int'(data_out1), 'hA);
        set_in(1, 0, 4'h0, 1, 1); tick();
        chk("alt_count0", int'(count0), 2);
        chk("alt_count1", int'(count1), 2);
        chk("alt_sel", int'(sel), 0);

        // Stall on lane 1, bypass onto lane 0.
        set_in(0, 0, 4'h0, 0, 0);
        do_reset();
        set_in(1, 0, 4'h0, 1, 0); tick();
        set_in(1, 1, 4'h1, 1, 0); tick();
        set_in(1, 1, 4'h2, 1, 0); tick();
        set_in(1, 1, 4'h3, 1, 0); tick();
        chk("stall_d0", int'(data_out0), 'h3);
        chk("stall_d1", int'(data_out1), 'h2);
        set_in(1, 1, 4'h4, 0, 0);
        #1;
        chk("stall_ready_low", int'(ready_out), 0);
        tick();
        set_in(1, 0, 4'h0, 0, 1); tick();
        chk("stall_count1", int'(count1), 1);

        // Same-cycle transfer and reload on lane 0.
        set_in(0, 0, 4'h0, 0, 0);
        do_reset();
        set_in(1, 0, 4'h0, 0, 0); tick();
        set_in(1, 1, 4'h9, 0, 0); tick();
        set_in(1, 1, 4'h4, 0, 0); tick();
        chk("reload_sel_before", int'(sel), 0);
        set_in(1, 1, 4'h5, 1, 0); tick();
        chk("reload_v0", int'(valid_out0), 1);
        chk("reload_d0", int'(data_out0), 'h5);
        chk("reload_count0", int'(count0), 1);

        // Drain with both lanes full, then drain-to-run recovery.
        set_in(0, 0, 4'h0, 0, 0);
        do_reset();
        set_in(1, 0, 4'h0, 0, 0); tick();
        set_in(1, 1, 4'hA, 0, 0); tick();
        set_in(1, 1, 4'hB, 0, 0); tick();
        set_in(0, 0, 4'h0, 0, 0); tick();
        chk("drain_busy", int'(busy), 1);
        chk("drain_ready", int'(ready_out), 0);
        set_in(0, 0, 4'h0, 1, 1); tick();
        chk("drain_still_busy", int'(busy), 1);
        tick();
        chk("drain_idle", int'(busy), 0);
        set_in(1, 0, 4'h0, 0, 1); tick();
        set_in(1, 1, 4'h6, 0, 1); tick();
        set_in(0, 0, 4'h0, 0, 1); tick();
        set_in(1, 0, 4'h0, 0, 1); tick();
        chk("drain_back_run", int'(ready_out), 1);
        chk("drain_back_busy", int'(busy), 1);

        // Counter wrap: 256 deliveries on each lane.
        set_in(0, 0, 4'h0, 0, 0);
        do_reset();
        set_in(1, 0, 4'h0, 1, 1); tick();
        for (int i = 0; i < 512; i++) begin
            set_in(1, 1, 4'(i), 1, 1);
            tick();
            if (i == 509) chk("wrap_count0_255", int'(count0), 255);
        end
        set_in(1, 0, 4'h0, 1, 1); tick();
        tick();
        chk("wrap_count0", int'(count0), 0);
        chk("wrap_count1", int'(count1), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                set_in(($urandom_range(0, 9) != 0),
                       1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)),
                       ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 9) < 5));
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_sched_4b.md
# demux_sched_4b

Round-robin scheduler that distributes a stream of 4-bit words from a single input bus onto two output lanes, in the role the 4-bit demultiplexer plays in the component library. It owns the demux select, holds one registered word per lane, and applies valid/ready backpressure on both sides. Each lane also has a delivered-word counter. It sits between a word source and two independent consumers. An enable input starts the block, and a drain sequence stops it cleanly.

## Interface
- WIDTH, 4, data word width
- CNT_W, 8, width of per-lane delivered-word counters
- clk  input  1  rising-edge clock
- reset_L  input  1  asynchronous, active-low reset
- enable  input  1  run request; 0 requests drain then idle
- data_in  input  WIDTH  input word
- valid_in  input  1  data_in valid
- ready_out  output  1  block accepts data_in this cycle
- data_out0 / data_out1  output  WIDTH  lane 0 / lane 1 registered word
- valid_out0 / valid_out1  output  1  lane word valid
- ready_in0 / ready_in1  input  1  lane consumer ready
- sel  output  1  preferred lane for next accepted word (round-robin pointer)
- busy  output  1  state != IDLE
- count0 / count1  output  CNT_W  words delivered on lane 0 / 1, wraps modulo 2^CNT_W

## Operation
- Reset (reset_L=0, asynchronous): state=IDLE, sel=0, valid_out0/1=0, data_out0/1=0, count0/1=0, busy=0, ready_out=0. Buffered words are discarded.
- FSM states:
  - IDLE: enable=1 moves to RUN.
  - RUN: enable=0 moves to DRAIN.
  - DRAIN: enable=1 moves back to RUN. Otherwise, once valid_out0=0 and valid_out1=0 (registered values), moves to IDLE.
- Lane availability: availN = !valid_outN || ready_inN, so a buffer is free or drains this cycle.
- ready_out = (state==RUN) && (avail0 || avail1). This is combinational from state, valid_outN and ready_inN. It does not depend on valid_in.
- Accept = valid_in && ready_out. Lane choice L:
  - L = sel if avail[sel].
  - Otherwise L = ~sel.
- On accept: data_outL <= data_in, valid_outL <= 1, sel <= ~L. sel is unchanged when nothing is accepted.
- Lane transfer = valid_outN && ready_inN. It increments countN, wrapping 2^CNT_W−1 → 0.
  - valid_outN clears unless the same cycle reloads lane N. On reload, valid stays 1 and data is replaced.
- data_outN holds its value while valid_outN=1 and ready_inN=0.
- No accepts in IDLE or DRAIN. Lane transfers continue in DRAIN and in IDLE (IDLE only after buffers are empty, so none occur).

## Timing
- Latency: a word accepted at edge k appears on data_outL with valid_outL=1 after edge k.
- Throughput: one word per cycle when both consumers hold ready=1. Lanes alternate 0,1,0,1….
- One lane stalled (ready_in=0, buffer full): all words go to the other lane at one per cycle. sel keeps pointing at the stalled lane.
- Both lanes full and not ready: ready_out=0. The source must hold data_in/valid_in.
- Counters update on the edge of the transfer. They are visible the cycle after.
- enable 1→0: the next edge enters DRAIN. ready_out drops combinationally in the same cycle the registered state becomes DRAIN.
- Drain length equals the cycles until both consumers take their words. It is 0 extra cycles if buffers are already empty: DRAIN→IDLE on the following edge.
- Reset asserted mid-transfer: outputs go to reset values immediately, without waiting for clk. Release is synchronous to the next rising edge.

## Test plan
- Reset: assert reset_L=0 between edges with both lanes valid → valid_out0/1, count0/1, sel, busy all 0 immediately. After release with enable=0, state stays IDLE and ready_out=0.
- Alternation: enable=1, ready_in0/1=1, stream 'hF,'h3,'h7,'hA → lane 0 gets F,7 and lane 1 gets 3,A, each one cycle after accept. count0=2, count1=2, sel=0 afterwards.
- Stall/bypass: ready_in1=0, stream 'h1,'h2,'h3 → lane 0 gets 1 and 3. Lane 1 holds 2 until ready_in1=1, then count1=1. ready_out=0 while lane 0 is also full with ready_in0=0.
- Simultaneous drain/reload: lane 0 valid with ready_in0=1 and sel=0, accept 'h5 the same cycle → valid_out0 stays 1, data_out0='h5, count0 increments by 1.
- Drain: two words buffered, ready_in0/1=0, drop enable → busy=1, ready_out=0. Raise ready_in0/1 → both transfer, then IDLE next edge and busy=0. Raising enable during DRAIN returns to RUN.
- Wrap: CNT_W=8, deliver 256 words on lane 0 → count0 reads 0x00 after the 256th transfer.
